// File: rtl/vector_stream_loader.sv
// vector_stream_loader
//   Parses a framed element stream: SYNC_LEN zero elements, a length word N,
//   NUM_VECTORS vectors of N elements, then TRAILER_LEN zero elements.
//   Every payload element is written to the operand RAM at consecutive
//   addresses. The first element of each vector is latched. Frame completion
//   and framing errors are flagged with sticky bits.
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high
//   element        incoming element (ELEMENT_WIDTH*8 bits)
//   element_ready  transfer strobe; one transfer per 0->1 transition
//   clear          synchronous return to S_SYNC, clears latches and counters
//   addr/wr_en/wr_data   operand RAM write port (1 cycle after the transfer)
//   vec_len        latched vector length N
//   first_elements first element of vector v at [v*EW +: EW]
//   state          current FSM state
//   done / error   sticky frame-complete / framing-error flags
module vector_stream_loader #(
  parameter int unsigned ELEMENT_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH    = 17,
  parameter int unsigned NUM_VECTORS   = 2,
  parameter int unsigned SYNC_LEN      = 3,
  parameter int unsigned TRAILER_LEN   = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [ELEMENT_WIDTH*8-1:0]             element,
  input  logic                                   element_ready,
  input  logic                                   clear,
  output logic [ADDR_WIDTH-1:0]                  addr,
  output logic                                   wr_en,
  output logic [ELEMENT_WIDTH*8-1:0]             wr_data,
  output logic [ADDR_WIDTH-1:0]                  vec_len,
  output logic [NUM_VECTORS*ELEMENT_WIDTH*8-1:0] first_elements,
  output logic [2:0]                             state,
  output logic                                   done,
  output logic                                   error
);

  localparam int unsigned EW   = ELEMENT_WIDTH * 8;
  localparam int unsigned AW   = ADDR_WIDTH;
  localparam int unsigned FW   = NUM_VECTORS * EW;
  localparam int unsigned VW   = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int unsigned CMAX = (SYNC_LEN > TRAILER_LEN) ? SYNC_LEN : TRAILER_LEN;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  // Wide enough to hold N*NUM_VECTORS without overflow
  localparam int unsigned PW   = AW + VW + 1;

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_LEN   = 3'd1,
    S_LOAD  = 3'd2,
    S_TRAIL = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            ready_q;
  logic [CW-1:0]   zcnt_q, zcnt_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   addr_d;
  logic            wr_en_d;
  logic [EW-1:0]   wr_data_d;
  logic [AW-1:0]   vec_len_d;
  logic [FW-1:0]   first_d;
  logic            done_d;
  logic            error_d;

  logic            xfer_c;
  logic [AW-1:0]   n_c;
  logic [PW-1:0]   total_c;
  logic            len_bad_c;

  // Rising edge of element_ready is one transfer
  assign xfer_c  = element_ready && !ready_q;
  assign n_c     = AW'(element);
  assign total_c = PW'(n_c) * PW'(NUM_VECTORS);
  // Zero length, stray high bits, or a frame that would overrun the RAM
  assign len_bad_c = (n_c == '0) ||
                     ((element >> ADDR_WIDTH) != '0) ||
                     (total_c > (PW'(1) << ADDR_WIDTH));

  assign state = 3'(state_q);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_SYNC;
      ready_q        <= 1'b0;
      zcnt_q         <= '0;
      tcnt_q         <= '0;
      idx_q          <= '0;
      vec_q          <= '0;
      base_q         <= '0;
      addr           <= '0;
      wr_en          <= 1'b0;
      wr_data        <= '0;
      vec_len        <= '0;
      first_elements <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state_q        <= state_d;
      ready_q        <= element_ready;
      zcnt_q         <= zcnt_d;
      tcnt_q         <= tcnt_d;
      idx_q          <= idx_d;
      vec_q          <= vec_d;
      base_q         <= base_d;
      addr           <= addr_d;
      wr_en          <= wr_en_d;
      wr_data        <= wr_data_d;
      vec_len        <= vec_len_d;
      first_elements <= first_d;
      done           <= done_d;
      error          <= error_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    zcnt_d    = zcnt_q;
    tcnt_d    = tcnt_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    base_d    = base_q;
    addr_d    = addr;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data;
    vec_len_d = vec_len;
    first_d   = first_elements;
    done_d    = done;
    error_d   = error;

    if (clear) begin
      // clear wins over a same-cycle transfer, which is dropped
      state_d   = S_SYNC;
      zcnt_d    = '0;
      tcnt_d    = '0;
      idx_d     = '0;
      vec_d     = '0;
      base_d    = '0;
      vec_len_d = '0;
      first_d   = '0;
      done_d    = 1'b0;
      error_d   = 1'b0;
    end else if (xfer_c) begin
      unique case (state_q)
        S_SYNC: begin
          if (element == '0) begin
            if (zcnt_q == CW'(SYNC_LEN - 1)) begin
              zcnt_d  = '0;
              state_d = S_LEN;
            end else begin
              zcnt_d = zcnt_q + CW'(1);
            end
          end else begin
            zcnt_d = '0;
          end
        end
        S_LEN: begin
          if (len_bad_c) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            vec_len_d = n_c;
            idx_d     = '0;
            vec_d     = '0;
            base_d    = '0;
            state_d   = S_LOAD;
          end
        end
        S_LOAD: begin
          wr_en_d   = 1'b1;
          addr_d    = base_q + idx_q;
          wr_data_d = element;
          if (idx_q == '0) begin
            for (int unsigned v = 0; v < NUM_VECTORS; v++) begin
              if (vec_q == VW'(v)) first_d[v*EW +: EW] = element;
            end
          end
          if (idx_q == vec_len - AW'(1)) begin
            idx_d  = '0;
            vec_d  = vec_q + VW'(1);
            base_d = base_q + vec_len;
            if (vec_q == VW'(NUM_VECTORS - 1)) begin
              tcnt_d = '0;
              if (TRAILER_LEN == 0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = S_TRAIL;
              end
            end
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
        S_TRAIL: begin
          if (element == '0) begin
            if (tcnt_q == CW'(TRAILER_LEN - 1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              tcnt_d = tcnt_q + CW'(1);
            end
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
